// File: rtl/tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_pkg
// Description : Shared widths, request type and response depth for the
//               true-dual-port RAM front-end controller.
// Revision    : 1.0 - initial release
// ============================================================================
package tdp_ram_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int RSP_DEPTH  = 2;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/tdp_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tdp_rsp_fifo
// Description : Small first-word-fall-through response FIFO with occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_rsp_fifo
    import tdp_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(RSP_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_empty,
    output logic [CNT_W-1:0]  o_count
);

    localparam int C_PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_W-1:0]  r_mem [RSP_DEPTH];
    logic [C_PTR_W-1:0] r_wptr;
    logic [C_PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_full;
    logic               w_pop;
    logic               w_push;

    function automatic logic [C_PTR_W-1:0] f_next(input logic [C_PTR_W-1:0] ptr);
        return (ptr == C_PTR_W'(RSP_DEPTH - 1)) ? '0 : ptr + C_PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_W'(RSP_DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_push  = i_push & (~w_full | w_pop);

    assign o_pop_data = r_mem[r_rptr];
    assign o_count    = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= f_next(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_next(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tdp_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_port_ctrl
// Description : Dual valid/ready front-end for a true-dual-port block RAM with
//               collision arbitration and credit-protected read responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tdp_ram_port_ctrl
    import tdp_ram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rsp_rdata,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rsp_rdata,
    output logic              ram_ena,
    output logic              ram_enb,
    output logic              ram_wea,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic [DATA_W-1:0] ram_dia,
    output logic [DATA_W-1:0] ram_dib,
    input  logic [DATA_W-1:0] ram_doa,
    input  logic [DATA_W-1:0] ram_dob
);

    localparam int   C_CNT_W  = $clog2(RSP_DEPTH + 1);
    localparam int   C_OCC_W  = C_CNT_W + 1;
    localparam logic C_PRIO_A = 1'b0;
    localparam logic C_PRIO_B = 1'b1;

    logic               r_run;
    logic               r_prio;
    logic               r_inflight_a;
    logic               r_inflight_b;
    logic [C_CNT_W-1:0] w_cnt_a;
    logic [C_CNT_W-1:0] w_cnt_b;
    logic               w_empty_a;
    logic               w_empty_b;
    logic [C_OCC_W-1:0] w_occ_a;
    logic [C_OCC_W-1:0] w_occ_b;
    logic               w_credit_a;
    logic               w_credit_b;
    logic               w_coll;

    // A read may only launch when its response already has a reserved FIFO slot.
    assign w_occ_a    = C_OCC_W'(w_cnt_a) + C_OCC_W'(r_inflight_a);
    assign w_occ_b    = C_OCC_W'(w_cnt_b) + C_OCC_W'(r_inflight_b);
    assign w_credit_a = a_req_we | (w_occ_a < C_OCC_W'(RSP_DEPTH));
    assign w_credit_b = b_req_we | (w_occ_b < C_OCC_W'(RSP_DEPTH));

    assign w_coll = a_req_valid & b_req_valid & (a_req_addr == b_req_addr)
                  & (a_req_we | b_req_we);

    assign a_req_ready = r_run & w_credit_a & (~w_coll | (r_prio == C_PRIO_A));
    assign b_req_ready = r_run & w_credit_b & (~w_coll | (r_prio == C_PRIO_B));

    assign ram_ena   = a_req_valid & a_req_ready;
    assign ram_enb   = b_req_valid & b_req_ready;
    assign ram_wea   = a_req_we & ram_ena;
    assign ram_web   = b_req_we & ram_enb;
    assign ram_addra = a_req_addr;
    assign ram_addrb = b_req_addr;
    assign ram_dia   = a_req_wdata;
    assign ram_dib   = b_req_wdata;

    assign a_rsp_valid = ~w_empty_a;
    assign b_rsp_valid = ~w_empty_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run        <= 1'b0;
            r_prio       <= C_PRIO_A;
            r_inflight_a <= 1'b0;
            r_inflight_b <= 1'b0;
        end else begin
            r_run        <= 1'b1;
            r_inflight_a <= ram_ena & ~ram_wea;
            r_inflight_b <= ram_enb & ~ram_web;
            if (w_coll) begin
                r_prio <= ~r_prio;
            end
        end
    end

    tdp_rsp_fifo #(
        .DATA_W (DATA_W),
        .CNT_W  (C_CNT_W)
    ) u_fifo_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight_a),
        .i_push_data (ram_doa),
        .i_pop       (a_rsp_ready),
        .o_pop_data  (a_rsp_rdata),
        .o_empty     (w_empty_a),
        .o_count     (w_cnt_a)
    );

    tdp_rsp_fifo #(
        .DATA_W (DATA_W),
        .CNT_W  (C_CNT_W)
    ) u_fifo_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight_b),
        .i_push_data (ram_dob),
        .i_pop       (b_rsp_ready),
        .o_pop_data  (b_rsp_rdata),
        .o_empty     (w_empty_b),
        .o_count     (w_cnt_b)
    );

endmodule
`default_nettype wire

// File: tb/tb_tdp_ram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdp_ram_port_ctrl
// Description : Scoreboard bench for tdp_ram_port_ctrl with a behavioural
//               read-first 1024x16 dual-port RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdp_ram_port_ctrl;

    typedef struct packed {
        logic [15:0] data;
        logic [31:0] acc;
        logic        lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req_valid, a_req_we, a_rsp_ready;
    logic [9:0]  a_req_addr;
    logic [15:0] a_req_wdata;
    logic        b_req_valid, b_req_we, b_rsp_ready;
    logic [9:0]  b_req_addr;
    logic [15:0] b_req_wdata;
    logic        a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
    logic [15:0] a_rsp_rdata, b_rsp_rdata;
    logic        ram_ena, ram_enb, ram_wea, ram_web;
    logic [9:0]  ram_addra, ram_addrb;
    logic [15:0] ram_dia, ram_dib;
    logic [15:0] ram_doa = 16'h0;
    logic [15:0] ram_dob = 16'h0;

    logic [15:0] mem [1024];
    logic [31:0] cyc = 32'd0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea_mon, eb_mon;
    logic [15:0] tbl [4];
    logic [31:0] ac, bc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Behavioural RAM: registered read data, read-before-write on each port.
    always @(posedge clk) begin
        if (ram_ena) begin
            ram_doa <= mem[ram_addra];
            if (ram_wea) mem[ram_addra] <= ram_dia;
        end
        if (ram_enb) begin
            ram_dob <= mem[ram_addrb];
            if (ram_web) mem[ram_addrb] <= ram_dib;
        end
    end

    tdp_ram_port_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .b_rsp_rdata (b_rsp_rdata),
        .ram_ena     (ram_ena),
        .ram_enb     (ram_enb),
        .ram_wea     (ram_wea),
        .ram_web     (ram_web),
        .ram_addra   (ram_addra),
        .ram_addrb   (ram_addrb),
        .ram_dia     (ram_dia),
        .ram_dib     (ram_dib),
        .ram_doa     (ram_doa),
        .ram_dob     (ram_dob)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (rst_n && a_rsp_valid) begin
            if (qa.size() == 0) chk("a_rsp_spurious", 32'(a_rsp_valid), 32'd0);
            else if (a_rsp_ready) begin
                ea_mon = qa.pop_front();
                chk("a_rsp_data", 32'(a_rsp_rdata), 32'(ea_mon.data));
                if (ea_mon.lat) chk("a_rsp_latency", cyc - ea_mon.acc, 32'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_rsp_valid) begin
            if (qb.size() == 0) chk("b_rsp_spurious", 32'(b_rsp_valid), 32'd0);
            else if (b_rsp_ready) begin
                eb_mon = qb.pop_front();
                chk("b_rsp_data", 32'(b_rsp_rdata), 32'(eb_mon.data));
                if (eb_mon.lat) chk("b_rsp_latency", cyc - eb_mon.acc, 32'd2);
            end
        end
    end

    // Presents one request per enabled port, holds each until accepted and
    // records the accept cycle; reads queue their expected data.
    task automatic issue(input logic av, input logic awe, input logic [9:0] aa,
                         input logic [15:0] ad, input logic [15:0] ax,
                         input logic bv, input logic bwe, input logic [9:0] ba,
                         input logic [15:0] bd, input logic [15:0] bx,
                         input logic lat, output logic [31:0] a_cyc, output logic [31:0] b_cyc);
        logic pa, pb, ga, gb;
        int   k;
        pa = av; pb = bv; a_cyc = '1; b_cyc = '1; k = 0;
        a_req_valid = av; a_req_we = awe; a_req_addr = aa; a_req_wdata = ad;
        b_req_valid = bv; b_req_we = bwe; b_req_addr = ba; b_req_wdata = bd;
        while ((pa || pb) && k < 20) begin
            @(negedge clk);
            ga = pa && a_req_ready;
            gb = pb && b_req_ready;
            if (ga) begin a_cyc = cyc; pa = 1'b0; if (!awe) qa.push_back('{ax, cyc, lat}); end
            if (gb) begin b_cyc = cyc; pb = 1'b0; if (!bwe) qb.push_back('{bx, cyc, lat}); end
            @(posedge clk); #1;
            if (ga) a_req_valid = 1'b0;
            if (gb) b_req_valid = 1'b0;
            k++;
        end
        if (pa || pb) begin
            chk("issue_timeout", {30'd0, pa, pb}, 32'd0);
            a_req_valid = 1'b0; b_req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 50) begin
            @(posedge clk); #1; k++;
        end
        chk("drain_timeout", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    task automatic wr(input logic port_b, input logic [9:0] ad, input logic [15:0] d);
        logic [31:0] x, y;
        issue(!port_b, 1'b1, ad, d, 16'h0, port_b, 1'b1, ad, d, 16'h0, 1'b0, x, y);
    endtask

    task automatic rd(input logic port_b, input logic [9:0] ad, input logic [15:0] e);
        logic [31:0] x, y;
        issue(!port_b, 1'b0, ad, 16'h0, e, port_b, 1'b0, ad, 16'h0, e, 1'b0, x, y);
        drain();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_a_req_ready"}, 32'(a_req_ready), 32'd0);
        chk({tag, "_b_req_ready"}, 32'(b_req_ready), 32'd0);
        chk({tag, "_a_rsp_valid"}, 32'(a_rsp_valid), 32'd0);
        chk({tag, "_b_rsp_valid"}, 32'(b_rsp_valid), 32'd0);
        chk({tag, "_ram_en_we"}, {28'd0, ram_ena, ram_enb, ram_wea, ram_web}, 32'd0);
        chk({tag, "_rsp_rdata"}, {a_rsp_rdata, b_rsp_rdata}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic g;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        tbl[0] = 16'hC0DE; tbl[1] = 16'hBEEF; tbl[2] = 16'h1111; tbl[3] = 16'h2222;
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
        #1;
        chk_quiet("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Write on A, read back on B with the minimum response latency.
        wr(1'b0, 10'h005, 16'h1234);
        issue(1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 1'b1, 1'b0, 10'h005, 16'h0, 16'h1234, 1'b1, ac, bc);
        drain();

        // Write/write collisions alternate the winner.
        issue(1'b1, 1'b1, 10'h010, 16'hAAAA, 16'h0, 1'b1, 1'b1, 10'h010, 16'h5555, 16'h0, 1'b0, ac, bc);
        chk("coll1_a_first", bc - ac, 32'd1);
        rd(1'b0, 10'h010, 16'h5555);
        issue(1'b1, 1'b1, 10'h010, 16'h1111, 16'h0, 1'b1, 1'b1, 10'h010, 16'h2222, 16'h0, 1'b0, ac, bc);
        chk("coll2_b_first", ac - bc, 32'd1);
        rd(1'b1, 10'h010, 16'h1111);

        // Same-address reads on both ports are not a collision.
        wr(1'b0, 10'h020, 16'h0F0F);
        issue(1'b1, 1'b0, 10'h020, 16'h0, 16'h0F0F, 1'b1, 1'b0, 10'h020, 16'h0, 16'h0F0F, 1'b0, ac, bc);
        chk("rr_same_cycle", bc - ac, 32'd0);
        drain();

        // Response backpressure: only two reads may be outstanding.
        for (int i = 0; i < 4; i++) wr(1'b0, 10'h030 + 10'(i), tbl[i]);
        a_rsp_ready = 1'b0;
        idx = 0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 10'h030;
        repeat (8) begin
            @(negedge clk);
            g = a_req_ready && (idx < 4);
            if (g) begin qa.push_back('{tbl[idx], cyc, 1'b0}); idx++; end
            @(posedge clk); #1;
            if (g) begin
                a_req_addr = 10'h030 + 10'(idx);
                if (idx == 4) a_req_valid = 1'b0;
            end
        end
        chk("bp_accepted", 32'(idx), 32'd2);
        @(negedge clk);
        chk("bp_ready_closed", 32'(a_req_ready), 32'd0);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("bp_ready_reopen", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;

        // Leave priority at B so the reset test can see it return to A.
        issue(1'b1, 1'b1, 10'h011, 16'h3333, 16'h0, 1'b1, 1'b1, 10'h011, 16'h4444, 16'h0, 1'b0, ac, bc);
        chk("coll3_a_first", bc - ac, 32'd1);

        // Reset right after a read issue discards it.
        issue(1'b1, 1'b0, 10'h005, 16'h0, 16'h1234, 1'b0, 1'b0, 10'h0, 16'h0, 16'h0, 1'b0, ac, bc);
        rst_n = 1'b0;
        qa.delete(); qb.delete();
        #1;
        chk_quiet("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("post_rst_no_rsp", {30'd0, a_rsp_valid, b_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        issue(1'b1, 1'b1, 10'h012, 16'h6666, 16'h0, 1'b1, 1'b1, 10'h012, 16'h7777, 16'h0, 1'b0, ac, bc);
        chk("post_rst_prio_a", bc - ac, 32'd1);
        rd(1'b0, 10'h012, 16'h7777);

        // Extreme addresses on both ports at once.
        wr(1'b1, 10'h000, 16'h7A7A);
        issue(1'b1, 1'b1, 10'h3FF, 16'hFACE, 16'h0, 1'b1, 1'b0, 10'h000, 16'h0, 16'h7A7A, 1'b0, ac, bc);
        chk("edge_same_cycle", bc - ac, 32'd0);
        drain();
        rd(1'b0, 10'h3FF, 16'hFACE);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
